// File: rtl/loby_pkg.sv
// Shared constants, FSM encoding and sizing helper for the LoBy host driver.
package loby_pkg;

  localparam int LOBY_SIZE     = 257;
  localparam int LOBY_SIZE_DIN = 64;
  localparam int LOBY_SQZ_BIT  = LOBY_SIZE_DIN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_GAP,
    ST_WAIT_MSG,
    ST_ISSUE,
    ST_CAPTURE,
    ST_OUT
  } drv_state_t;

  function automatic int gap_cnt_w(input int gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

endpackage

// File: rtl/loby_gap_timer.sv
// Loadable down-counter used to time the idle gap after each core operation.
module loby_gap_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/loby_driver.sv
// Host-side sequencer for one LoBy core: key/word intake, pulse generation, tag return.
// LOBY_DRV_ALL_SQZ_EN: emit one tag per squeeze instead of one tag per session.
//
// state    | meaning
// IDLE     | waiting for a session key
// INIT     | one-cycle core_init pulse
// GAP      | idle cycles after a core operation
// WAIT_MSG | waiting for the next tagged word
// ISSUE    | one-cycle din_valid (and sqz) pulse
// CAPTURE  | sample core_dout into the tag register
// OUT      | presenting a tag until accepted
module loby_driver
  import loby_pkg::*;
#(
  parameter int SIZE       = LOBY_SIZE,
  parameter int SIZE_DIN   = LOBY_SIZE_DIN,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [SIZE-1:0]     key_data,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [SIZE_DIN:0]   msg_data,
  input  logic                msg_last,
  output logic                tag_valid,
  input  logic                tag_ready,
  output logic [SIZE-1:0]     tag_data,
  output logic                tag_err,
  output logic                tag_last,
  output logic                core_init,
  output logic                core_sqz,
  output logic                core_din_valid,
  output logic [SIZE_DIN-1:0] core_din,
  output logic [SIZE-1:0]     core_key,
  input  logic [SIZE-1:0]     core_dout
);

  localparam int GW = gap_cnt_w(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  drv_state_t state_q, state_d, after_op;
  logic key_ready_q, key_ready_d, msg_ready_q, msg_ready_d, tag_valid_q, tag_valid_d;
  logic init_q, init_d, sqz_q, sqz_d, dv_q, dv_d;
  logic [SIZE_DIN-1:0] din_q, din_d;
  logic [SIZE-1:0] key_q, key_d, tag_data_q, tag_data_d;
  logic tag_err_q, tag_err_d, tag_last_q, tag_last_d;
  logic word_sqz_q, word_sqz_d, word_last_q, word_last_d;
  logic sqz_seen_q, sqz_seen_d, pend_q, pend_d, pend_set;
  logic key_acc, msg_acc, tag_acc, to_out, gap_done;

  assign key_acc = (state_q == ST_IDLE) && key_valid && key_ready_q;
  assign msg_acc = (state_q == ST_WAIT_MSG) && msg_valid && msg_ready_q;
  assign tag_acc = tag_valid_q && tag_ready;

`ifdef LOBY_DRV_ALL_SQZ_EN
  assign pend_set = (state_q == ST_CAPTURE);
`else
  assign pend_set = (state_q == ST_CAPTURE) && word_last_q;
`endif
  assign pend_d     = pend_set || (pend_q && !tag_acc);
  assign sqz_seen_d = key_acc ? 1'b0 : ((state_q == ST_CAPTURE) || sqz_seen_q);

  // With no gap configured, the gap exit decision is taken directly by the operation state.
  assign to_out   = pend_d || word_last_q;
  assign after_op = (GAP_CYCLES == 0) ? (to_out ? ST_OUT : ST_WAIT_MSG) : ST_GAP;

  loby_gap_timer #(.W(GW)) u_gap (
    .clk        (clk),
    .arstn      (arstn),
    .load_i     ((state_d == ST_GAP) && (state_q != ST_GAP)),
    .load_val_i (GAP_LOAD),
    .done_o     (gap_done)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_IDLE;
      key_ready_q <= 1'b0;
      msg_ready_q <= 1'b0;
      tag_valid_q <= 1'b0;
      init_q      <= 1'b0;
      sqz_q       <= 1'b0;
      dv_q        <= 1'b0;
      din_q       <= '0;
      key_q       <= '0;
      tag_data_q  <= '0;
      tag_err_q   <= 1'b0;
      tag_last_q  <= 1'b0;
      word_sqz_q  <= 1'b0;
      word_last_q <= 1'b0;
      sqz_seen_q  <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      msg_ready_q <= msg_ready_d;
      tag_valid_q <= tag_valid_d;
      init_q      <= init_d;
      sqz_q       <= sqz_d;
      dv_q        <= dv_d;
      din_q       <= din_d;
      key_q       <= key_d;
      tag_data_q  <= tag_data_d;
      tag_err_q   <= tag_err_d;
      tag_last_q  <= tag_last_d;
      word_sqz_q  <= word_sqz_d;
      word_last_q <= word_last_d;
      sqz_seen_q  <= sqz_seen_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (key_acc) state_d = ST_INIT;
      ST_INIT:     state_d = after_op;
      ST_GAP:      if (gap_done) state_d = to_out ? ST_OUT : ST_WAIT_MSG;
      ST_WAIT_MSG: if (msg_acc) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = word_sqz_q ? ST_CAPTURE : after_op;
      ST_CAPTURE:  state_d = after_op;
      ST_OUT:      if (tag_acc) state_d = tag_last_q ? ST_IDLE : ST_WAIT_MSG;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered: decode the next state so each pulse lines up with its state.
  always_comb begin
    key_ready_d = (state_d == ST_IDLE);
    msg_ready_d = (state_d == ST_WAIT_MSG);
    tag_valid_d = (state_d == ST_OUT);
    init_d      = (state_d == ST_INIT);
    dv_d        = (state_d == ST_ISSUE);
    key_d       = key_q;
    din_d       = din_q;
    word_sqz_d  = word_sqz_q;
    word_last_d = word_last_q;
    tag_data_d  = tag_data_q;
    tag_err_d   = tag_err_q;
    tag_last_d  = tag_last_q;
    if (key_acc) begin
      key_d       = key_data;
      word_last_d = 1'b0;
    end
    if (msg_acc) begin
      din_d       = msg_data[SIZE_DIN-1:0];
      word_sqz_d  = msg_data[SIZE_DIN];
      word_last_d = msg_last;
    end
    sqz_d = dv_d && word_sqz_d;
    if (state_q == ST_CAPTURE)
      tag_data_d = core_dout;
    if ((state_d == ST_OUT) && (state_q != ST_OUT)) begin
      tag_last_d = word_last_q;
      tag_err_d  = 1'b0;
`ifdef LOBY_DRV_ALL_SQZ_EN
      if (word_last_q && !word_sqz_q) begin
        tag_data_d = '0;
        tag_err_d  = !sqz_seen_d;
      end
`else
      if (word_last_q && !sqz_seen_d) begin
        tag_data_d = '0;
        tag_err_d  = 1'b1;
      end
`endif
    end
  end

  assign key_ready      = key_ready_q;
  assign msg_ready      = msg_ready_q;
  assign tag_valid      = tag_valid_q;
  assign tag_data       = tag_data_q;
  assign tag_err        = tag_err_q;
  assign tag_last       = tag_last_q;
  assign core_init      = init_q;
  assign core_sqz       = sqz_q;
  assign core_din_valid = dv_q;
  assign core_din       = din_q;
  assign core_key       = key_q;

endmodule

// File: tb/tb_loby_driver.sv
// Scoreboard bench for loby_driver: directed sessions against a din-XOR-key core model.
module tb_loby_driver;
  import loby_pkg::*;

  localparam int SZ = 257;
  localparam int DW = 64;

  typedef struct packed { logic [SZ-1:0] d; logic err; logic last; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic arstn = 1'b0;
  logic key_valid = 1'b0, key_ready, msg_valid = 1'b0, msg_ready, msg_last = 1'b0;
  logic [SZ-1:0] key_data = '0, tag_data, core_key, core_dout = '0;
  logic [DW:0] msg_data = '0;
  logic tag_valid, tag_ready = 1'b1, tag_err, tag_last, core_init, core_sqz, core_din_valid;
  logic [DW-1:0] core_din;

  logic key_valid_z = 1'b0, key_ready_z, msg_valid_z = 1'b0, msg_ready_z, msg_last_z = 1'b0;
  logic [SZ-1:0] key_data_z = '0, tag_data_z, core_key_z, core_dout_z = '0;
  logic [DW:0] msg_data_z = '0;
  logic tag_valid_z, tag_err_z, tag_last_z, core_init_z, core_sqz_z, core_din_valid_z;
  logic [DW-1:0] core_din_z;

  loby_driver #(.SIZE(SZ), .SIZE_DIN(DW), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .arstn(arstn),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_data(tag_data),
    .tag_err(tag_err), .tag_last(tag_last),
    .core_init(core_init), .core_sqz(core_sqz), .core_din_valid(core_din_valid),
    .core_din(core_din), .core_key(core_key), .core_dout(core_dout));

  loby_driver #(.SIZE(SZ), .SIZE_DIN(DW), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .arstn(arstn),
    .key_valid(key_valid_z), .key_ready(key_ready_z), .key_data(key_data_z),
    .msg_valid(msg_valid_z), .msg_ready(msg_ready_z), .msg_data(msg_data_z), .msg_last(msg_last_z),
    .tag_valid(tag_valid_z), .tag_ready(1'b1), .tag_data(tag_data_z),
    .tag_err(tag_err_z), .tag_last(tag_last_z),
    .core_init(core_init_z), .core_sqz(core_sqz_z), .core_din_valid(core_din_valid_z),
    .core_din(core_din_z), .core_key(core_key_z), .core_dout(core_dout_z));

  // Core model: a squeeze makes dout = key XOR zero-extended din on the next cycle.
  always @(posedge clk) begin
    if (core_din_valid && core_sqz) core_dout <= core_key ^ SZ'(core_din);
    if (core_din_valid_z && core_sqz_z) core_dout_z <= core_key_z ^ SZ'(core_din_z);
  end

  function automatic logic [SZ-1:0] mdl(input logic [SZ-1:0] k, input logic [DW-1:0] d);
    return k ^ SZ'(d);
  endfunction

  int n_chk = 0, n_bad = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [SZ-1:0] got, input logic [SZ-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chki(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input logic [SZ-1:0] d, input logic e, input logic l);
    exp_t x;
    x.d = d; x.err = e; x.last = l;
    sb.push_back(x);
  endtask

  // Monitor: samples 2 time units after the falling edge, well clear of the rising edge.
  int n_init = 0, n_sqz = 0, init_cyc = -1, tv_rise = -1;
  logic sqz_wide = 1'b0, both_rdy = 1'b0, b2b_z = 1'b0;
  logic prev_sqz = 1'b0, prev_tv = 1'b0, prev_dvz = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (arstn) begin
      if (core_init) begin n_init++; init_cyc = cyc; end
      if (core_din_valid && core_sqz) n_sqz++;
      if (core_sqz && prev_sqz) sqz_wide = 1'b1;
      if (msg_ready && key_ready) both_rdy = 1'b1;
      if (tag_valid && !prev_tv) tv_rise = cyc;
      if (core_din_valid_z && prev_dvz) b2b_z = 1'b1;
      if (tag_valid && tag_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL unexpected_tag got=%0h want=none", tag_data);
        end else begin
          e = sb.pop_front();
          chk("tag_data", tag_data, e.d);
          chki("tag_err", int'(tag_err), int'(e.err));
          chki("tag_last", int'(tag_last), int'(e.last));
        end
      end
    end
    prev_sqz = core_sqz;
    prev_tv  = tag_valid;
    prev_dvz = core_din_valid_z;
  end

  task automatic send_key(input logic [SZ-1:0] k, output int t);
    int n = 0;
    @(negedge clk);
    key_data = k; key_valid = 1'b1;
    while (!key_ready && n < 60) begin @(negedge clk); n++; end
    chki("key_accept", int'(key_ready), 1);
    t = cyc;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_word(input logic s, input logic [DW-1:0] d, input logic l, output int t);
    int n = 0;
    @(negedge clk);
    msg_data = '0;
    msg_data[LOBY_SQZ_BIT] = s;
    msg_data[DW-1:0] = d;
    msg_last = l; msg_valid = 1'b1;
    while (!msg_ready && n < 60) begin @(negedge clk); n++; end
    chki("msg_accept", int'(msg_ready), 1);
    t = cyc;
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(sb.size() == 0 && key_ready) && n < 200) begin @(negedge clk); n++; end
    chki("drain_to_idle", int'(sb.size() == 0 && key_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SZ-1:0] k1, k2, k3, k4, k5, k6;
    logic [DW-1:0] wa, wb, wc, wd;
    int t0, ta, tb, tc, td, n, tz, az, cz;
    k1 = 257'h1;
    k2 = 257'h1 << 256;
    k3 = 257'hABCDEF;
    k4 = {1'b0, {4{64'hCAFE_F00D_1357_9BDF}}};
    k5 = 257'h5A5A_0000_1111;
    k6 = 257'h77 << 130;
    wa = 64'h0123_4567_89AB_CDEF;
    wb = 64'hFEDC_BA98_7654_3210;
    wc = 64'hDEAD_BEEF_0000_0001;
    wd = 64'h5555_AAAA_1234_5678;

    // reset state
    repeat (2) @(negedge clk);
    chki("rst_handshakes", int'({key_ready, msg_ready, tag_valid}), 0);
    chki("rst_pulses", int'({core_init, core_sqz, core_din_valid}), 0);
    chk("rst_core_key", core_key, '0);
    chk("rst_core_din", SZ'(core_din), '0);
    chki("rst_tag_flags", int'({tag_err, tag_last}), 0);
    chk("rst_tag_data", tag_data, '0);
    arstn = 1'b1;

    // session 1: abs A, abs B, sqz C, sqz D+last
`ifdef LOBY_DRV_ALL_SQZ_EN
    push(mdl(k1, wc), 1'b0, 1'b0);
`endif
    push(mdl(k1, wd), 1'b0, 1'b1);
    n_init = 0; n_sqz = 0; sqz_wide = 1'b0;
    send_key(k1, t0);
    send_word(1'b0, wa, 1'b0, ta);
    chki("first_msg_ready", ta, t0 + 4);
    chki("init_cycle", init_cyc, t0 + 1);
    send_word(1'b0, wb, 1'b0, tb);
    chki("absorb_spacing", tb - ta, 4);
    send_word(1'b1, wc, 1'b0, tc);
    send_word(1'b1, wd, 1'b1, td);
`ifdef LOBY_DRV_ALL_SQZ_EN
    chki("sqz_spacing", td - tc, 6);
`else
    chki("sqz_spacing", td - tc, 5);
`endif
    drain();
    chki("final_tag_rise", tv_rise, td + 5);
    chki("init_pulses", n_init, 1);
    chki("sqz_pulses", n_sqz, 2);
    chki("sqz_width_1", int'(sqz_wide), 0);

    // session 2: lone absorb word, tag held off for 10 cycles
    tag_ready = 1'b0;
    push('0, 1'b1, 1'b1);
    send_key(k2, t0);
    send_word(1'b0, 64'hFF, 1'b1, ta);
    n = 0;
    while (!tag_valid && n < 60) begin @(negedge clk); n++; end
    chki("stall_tag_rise", cyc, ta + 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chki("stall_valid", int'(tag_valid), 1);
      chk("stall_data", tag_data, '0);
      chki("stall_key_ready", int'(key_ready), 0);
      chki("stall_core_idle", int'({core_init, core_sqz, core_din_valid}), 0);
    end
    tag_ready = 1'b1;
    @(negedge clk);
    chki("post_hs_idle", int'(key_ready), 1);
    chki("post_hs_valid", int'(tag_valid), 0);
    drain();

    // session 3: reset during ISSUE aborts without a tag
    send_key(k3, t0);
    send_word(1'b0, 64'h1234, 1'b0, ta);
    chki("issue_before_rst", int'(core_din_valid), 1);
    #1 arstn = 1'b0;
    #1;
    chki("rst_mid_pulses", int'({core_init, core_sqz, core_din_valid}), 0);
    chki("rst_mid_handshakes", int'({key_ready, msg_ready, tag_valid}), 0);
    chk("rst_mid_core_key", core_key, '0);
    chk("rst_mid_core_din", SZ'(core_din), '0);
    @(negedge clk);
    arstn = 1'b1;

    // session 4: fresh session after reset, single final squeeze
    push(mdl(k4, wb), 1'b0, 1'b1);
    send_key(k4, t0);
    send_word(1'b1, wb, 1'b1, ta);
    drain();
    chki("sess4_tag_rise", tv_rise, ta + 5);
    chk("sess4_core_key_held", core_key, k4);

    // session 5: sqz X, sqz Y+last
`ifdef LOBY_DRV_ALL_SQZ_EN
    push(mdl(k5, wa), 1'b0, 1'b0);
`endif
    push(mdl(k5, wc), 1'b0, 1'b1);
    send_key(k5, t0);
    send_word(1'b1, wa, 1'b0, ta);
    send_word(1'b1, wc, 1'b1, tb);
    drain();

    // session 6: sqz P, abs Q+last
`ifdef LOBY_DRV_ALL_SQZ_EN
    push(mdl(k6, wd), 1'b0, 1'b0);
    push('0, 1'b0, 1'b1);
`else
    push(mdl(k6, wd), 1'b0, 1'b1);
`endif
    send_key(k6, t0);
    send_word(1'b1, wd, 1'b0, ta);
    send_word(1'b0, wa, 1'b1, tb);
    drain();
    chki("never_both_ready", int'(both_rdy), 0);

    // zero-gap instance: abs A then sqz C+last
    b2b_z = 1'b0;
    @(negedge clk);
    key_data_z = k1; key_valid_z = 1'b1;
    n = 0;
    while (!key_ready_z && n < 20) begin @(negedge clk); n++; end
    tz = cyc;
    @(negedge clk);
    key_valid_z = 1'b0;
    msg_valid_z = 1'b1; msg_data_z = {1'b0, wa}; msg_last_z = 1'b0;
    n = 0;
    while (!msg_ready_z && n < 20) begin @(negedge clk); n++; end
    az = cyc;
    chki("gap0_first_msg_ready", az, tz + 2);
    @(negedge clk);
    msg_data_z = {1'b1, wc}; msg_last_z = 1'b1;
    n = 0;
    while (!msg_ready_z && n < 20) begin @(negedge clk); n++; end
    cz = cyc;
    chki("gap0_absorb_spacing", cz - az, 2);
    @(negedge clk);
    msg_valid_z = 1'b0;
    n = 0;
    while (!tag_valid_z && n < 20) begin @(negedge clk); n++; end
    chki("gap0_tag_rise", cyc, cz + 3);
    chk("gap0_tag_data", tag_data_z, mdl(k1, wc));
    chki("gap0_tag_flags", int'({tag_err_z, tag_last_z}), 1);
    @(negedge clk);
    chki("gap0_no_b2b_issue", int'(b2b_z), 0);
    chki("gap0_back_idle", int'(key_ready_z), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
